uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial-to-parallel UART receiver. It is the companion of the existing uart_tx and shares its tick source and framing: 1 start bit, DATA_BITS data bits sent LSB first, and 1 stop bit, with SB_TICKS oversampling ticks per bit. It samples each bit at mid-bit, rejects false starts, and flags framing errors. It also waits for the line to return to idle after a break before it accepts a new frame. Output goes to the receive-side FIFO/interface logic, which consumes rx_done_tick and dout.

Parameters:
DATA_BITS, `DATA_BITS (8), number of data bits per frame.
SB_TICKS, `SB_TICKS (16), s_tick pulses per bit period; must be even and >= 4.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
s_tick  in  1  oversampling enable pulse from the baud generator, one clk wide.
rx  in  1  raw serial line; asynchronous; idle high.
dout  out  DATA_BITS  last received word; holds until the next rx_done_tick.
rx_done_tick  out  1  one-clk pulse: frame complete and dout/frame_err updated.
frame_err  out  1  stop bit sampled low for the frame reported by the current/last rx_done_tick.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; s, n and b counters/shift register cleared.
  - sync flops=1; dout=0, rx_done_tick=0, frame_err=0.
  - s_tick and rx are ignored while reset is asserted.
- Synchronizer: rx passes through 2 flops → rx_s. All decisions use rx_s only, giving 2 clk of input latency.
- Counters: s counts ticks within a bit (width `S_REG_SIZE); n counts data bits (width `N_REG_SIZE); b is the shift register (width DATA_BITS). s and n change only on clk edges where s_tick=1, except in IDLE.
- IDLE:
  - rx_s==0 (independent of s_tick) → START, s=0.
- START:
  - On s_tick, when s==SB_TICKS/2-1 (mid start bit):
    - rx_s==0 → DATA, s=0, n=0.
    - rx_s==1 → glitch: back to IDLE, no output activity.
  - Otherwise s+1.
- DATA:
  - On s_tick, when s==SB_TICKS-1 (mid data bit):
    - s=0; b={rx_s, b[DATA_BITS-1:1]} (LSB first).
    - n==DATA_BITS-1 → STOP; else n+1.
  - Otherwise s+1.
- STOP:
  - On s_tick, when s==SB_TICKS-1 (mid stop bit):
    - dout<=b; frame_err<=~rx_s; rx_done_tick<=1 for the next clk only (registered output).
    - Next state: rx_s==1 → IDLE; rx_s==0 → WAIT_IDLE.
  - Otherwise s+1.
- WAIT_IDLE:
  - Stay until rx_s==1, then → IDLE.
  - No start detection here, so a held-low line or break produces exactly one frame_err report.
- Completion timing: completion occurs half a stop bit early, so back-to-back frames with a single-bit stop period are received with no loss.
- Output holding: dout and frame_err are valid from the rx_done_tick cycle and hold until the next completed frame. A glitch-rejected start never changes them.
- Reset mid-frame: the frame is abandoned immediately, with no rx_done_tick, and outputs return to their reset values.
- Tick/start overlap: s_tick coinciding with the IDLE→START transition is not counted; s starts at 0 on the next tick.

Decomposition:
- Add to uart_tx_rx.vh:
  - `UART_RX_STATE_IDLE/START/DATA/STOP/WAIT_IDLE`
  - `UART_RX_STATE_REG_SIZE` (3)
- Reuse `S_REG_SIZE`, `N_REG_SIZE`, `B_REG_SIZE`, `DATA_BITS`, `SB_TICKS`, and `HIGH`/`LOW`/`CLEAR` from common.vh.
- One sub-module: uart_rx_sync, a 2-flop synchronizer (reset value 1, parameterised reset value), reusable for other async inputs.

Test Plan:
- Common setup: SB_TICKS=16, DATA_BITS=8, s_tick every 4 clk.
- Reset: hold reset=0 while toggling rx/s_tick → dout=0x00, rx_done_tick=0, frame_err=0. Release; line idle → no pulse.
- Single frame 0xA5, stop=1 → exactly one rx_done_tick; dout=0xA5, frame_err=0. Pulse occurs 8 ticks (+sync latency) into the stop bit.
- Glitch: rx low for 4 ticks, then high → no rx_done_tick, dout unchanged. A following 0x3C frame is received correctly.
- Framing/break: 0x00 with stop bit low, line held low 40 further ticks → one pulse with dout=0x00, frame_err=1, and no further pulses. Line high, then frame 0x81 → dout=0x81, frame_err=0.
- Back-to-back: 0x55 then 0xAA, each stop bit exactly 16 ticks → two pulses; dout=0x55 then 0xAA; frame_err=0 both.
- Reset mid-frame: assert reset after the 3rd data bit of 0x12 → no pulse, outputs cleared. After release, frame 0xFF → dout=0xFF, frame_err=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver.
// Provides the receiver state encoding, the default frame geometry
// and a helper that sizes counters from their terminal count.
package uart_rx_pkg;

  // Default frame geometry: 8 data bits, 16 oversampling ticks per bit.
  localparam int DATA_BITS_DEF = 8;
  localparam int SB_TICKS_DEF  = 16;

  // Line levels and the cleared value used by counters and registers.
  localparam logic HIGH  = 1'b1;
  localparam logic LOW   = 1'b0;
  localparam logic CLEAR = 1'b0;

  localparam int UART_RX_STATE_REG_SIZE = 3;

  // Receiver states.
  // WAIT_IDLE is entered after a stop bit sampled low. It holds off start
  // detection until the line goes high, so a break reports one error only.
  typedef enum logic [UART_RX_STATE_REG_SIZE-1:0] {
    UART_RX_STATE_IDLE      = 3'd0,
    UART_RX_STATE_START     = 3'd1,
    UART_RX_STATE_DATA      = 3'd2,
    UART_RX_STATE_STOP      = 3'd3,
    UART_RX_STATE_WAIT_IDLE = 3'd4
  } uart_rx_state_e;

  // Width of a counter that has to hold values 0 .. count-1 (at least 1 bit).
  function automatic int reg_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for one asynchronous input.
// Ports: clk (sampling clock), reset (async, active low), i_async (raw input),
//        o_sync (synchronized copy, 2 clk of latency). Both flops reset to RST_VAL.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // The first flop may go metastable. Only the second flop is seen downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (1 start, DATA_BITS data LSB first, 1 stop).
// Ports: clk, reset (async active low), s_tick (baud x SB_TICKS enable), rx (raw line),
//        dout (last word), rx_done_tick (1-clk completion pulse), frame_err (stop bit low).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int SB_TICKS  = SB_TICKS_DEF    // must be even and >= 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_err
);

  localparam int S_REG_SIZE = reg_width(SB_TICKS);
  localparam int N_REG_SIZE = reg_width(DATA_BITS);
  localparam int B_REG_SIZE = DATA_BITS;

  // Terminal counts. The start bit ends at half a bit so that every later
  // sample falls in the middle of its bit.
  localparam logic [S_REG_SIZE-1:0] S_MID  = S_REG_SIZE'(SB_TICKS / 2 - 1);
  localparam logic [S_REG_SIZE-1:0] S_LAST = S_REG_SIZE'(SB_TICKS - 1);
  localparam logic [S_REG_SIZE-1:0] S_ONE  = S_REG_SIZE'(1);
  localparam logic [N_REG_SIZE-1:0] N_LAST = N_REG_SIZE'(DATA_BITS - 1);
  localparam logic [N_REG_SIZE-1:0] N_ONE  = N_REG_SIZE'(1);

  logic                  w_rx_s;
  uart_rx_state_e        r_state;
  logic [S_REG_SIZE-1:0] r_s;
  logic [N_REG_SIZE-1:0] r_n;
  logic [B_REG_SIZE-1:0] r_b;
  logic [DATA_BITS-1:0]  r_dout;
  logic                  r_done;
  logic                  r_ferr;

  // The line idles high, so the synchronizer also resets high. Otherwise
  // leaving reset would look like a start bit.
  uart_rx_sync #(
    .RST_VAL (HIGH)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= UART_RX_STATE_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= CLEAR;
      r_ferr  <= CLEAR;
    end else begin
      r_done <= CLEAR;

      case (r_state)
        // A falling edge is acted on at once, whether or not a tick is present.
        // A tick in this same cycle is not counted, so r_s starts from 0.
        UART_RX_STATE_IDLE: begin
          if (w_rx_s == LOW) begin
            r_state <= UART_RX_STATE_START;
            r_s     <= '0;
          end
        end

        // Check the line again at mid start bit. If it is high, the low
        // pulse was a glitch: drop it and leave the outputs alone.
        UART_RX_STATE_START: begin
          if (s_tick) begin
            if (r_s == S_MID) begin
              if (w_rx_s == LOW) begin
                r_state <= UART_RX_STATE_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= UART_RX_STATE_IDLE;
              end
            end else begin
              r_s <= r_s + S_ONE;
            end
          end
        end

        // One full bit period after the previous mid-bit lands at mid data
        // bit. Bits arrive LSB first, so shift them in from the top.
        UART_RX_STATE_DATA: begin
          if (s_tick) begin
            if (r_s == S_LAST) begin
              r_s <= '0;
              r_b <= {w_rx_s, r_b[B_REG_SIZE-1:1]};
              if (r_n == N_LAST) begin
                r_state <= UART_RX_STATE_STOP;
              end else begin
                r_n <= r_n + N_ONE;
              end
            end else begin
              r_s <= r_s + S_ONE;
            end
          end
        end

        // The frame completes at mid stop bit, not at the end of it. The
        // half bit left over absorbs baud skew, so a following start bit
        // right after a one-bit stop is not missed.
        UART_RX_STATE_STOP: begin
          if (s_tick) begin
            if (r_s == S_LAST) begin
              r_dout <= r_b;
              r_ferr <= ~w_rx_s;
              r_done <= HIGH;
              r_state <= (w_rx_s == HIGH) ? UART_RX_STATE_IDLE
                                          : UART_RX_STATE_WAIT_IDLE;
            end else begin
              r_s <= r_s + S_ONE;
            end
          end
        end

        // After a low stop bit (break or line held low), wait for the line
        // to go high before looking for a start bit again.
        UART_RX_STATE_WAIT_IDLE: begin
          if (w_rx_s == HIGH) begin
            r_state <= UART_RX_STATE_IDLE;
          end
        end

        default: begin
          r_state <= UART_RX_STATE_IDLE;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (DATA_BITS=8, SB_TICKS=16, tick every 4 clk).
// Frames are built bit by bit on a tick grid. Every frame that is sent predicts one
// pulse carrying {data, ~stop}. A monitor logs pulses and the main thread compares them.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int SB = 16;

  logic          clk;
  logic          reset;
  logic          s_tick;
  logic          rx;
  logic [DB-1:0] dout;
  logic          rx_done_tick;
  logic          frame_err;

  uart_rx #(
    .DATA_BITS (DB),
    .SB_TICKS  (SB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       f;
    int         cyc;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_after;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  obs_t obs_q[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   tcnt;
  logic [7:0] last_d;
  logic       last_f;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // s_tick: one clk wide, every 4 clk. It keeps running during reset.
  initial begin
    tcnt   = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt   = (tcnt + 1) % 4;
      s_tick = (tcnt == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) obs_q.push_back('{dout, frame_err, cyc});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns at the negedge just after the n-th tick, so rx changes on the tick grid.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int n);
    rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int low_after,
                            input int gap, output int stop_cyc);
    send_bit(1'b0, SB);
    for (int i = 0; i < DB; i++) send_bit(d[i], SB);
    stop_cyc = cyc;
    send_bit(stop, SB);
    if (low_after > 0) send_bit(1'b0, low_after);
    rx = 1'b1;
    if (gap > 0) wait_ticks(gap);
  endtask

  // Exactly one pulse is expected per frame, carrying the word and the stop-bit verdict.
  task automatic check_frame(input string name, input logic [7:0] ed, input logic ef);
    obs_t o;
    chk({name, " pulse count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q[0];
      chk({name, " dout"}, o.d, ed);
      chk({name, " frame_err"}, o.f, ef);
    end
    obs_q.delete();
    last_d = ed;
    last_f = ef;
  endtask

  vec_t tbl[6];

  initial begin
    int sc;
    obs_t o;
    logic [7:0] d;
    logic [7:0] pat;
    logic stp;
    int la;
    int gp;

    n_cmp  = 0;
    n_bad  = 0;
    cyc    = 0;
    last_d = 8'h00;
    last_f = 1'b0;

    tbl[0] = '{8'h00, 1'b0, 40, 4, 8'h00, 1'b1};
    tbl[1] = '{8'h81, 1'b1, 0,  4, 8'h81, 1'b0};
    tbl[2] = '{8'h55, 1'b1, 0,  0, 8'h55, 1'b0};
    tbl[3] = '{8'hAA, 1'b1, 0,  3, 8'hAA, 1'b0};
    tbl[4] = '{8'h7E, 1'b0, 0,  1, 8'h7E, 1'b1};
    tbl[5] = '{8'hC3, 1'b1, 0,  2, 8'hC3, 1'b0};

    // Hold reset while the inputs toggle. The outputs must stay at their reset values.
    reset = 1'b0;
    rx    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = $urandom_range(0, 1);
      if (i % 8 == 7) chk("reset outputs", {dout, rx_done_tick, frame_err}, 10'h0);
    end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    wait_ticks(40);
    chk("idle after reset: pulses", obs_q.size(), 0);
    chk("idle after reset: dout", dout, 8'h00);

    // Single frame. The pulse must come 8 ticks (32 clk) into the stop bit.
    send_frame(8'hA5, 1'b1, 0, 4, sc);
    if (obs_q.size() > 0) begin
      o = obs_q[0];
      chk("A5 pulse offset into stop bit", o.cyc - sc, 32);
    end
    check_frame("A5", 8'hA5, 1'b0);

    // Glitch: 4 ticks low is rejected at mid start bit. Then a real frame follows.
    send_bit(1'b0, 4);
    send_bit(1'b1, 16);
    chk("glitch pulses", obs_q.size(), 0);
    chk("glitch dout held", dout, 8'hA5);
    chk("glitch frame_err held", frame_err, 1'b0);
    send_frame(8'h3C, 1'b1, 0, 4, sc);
    check_frame("3C", 8'h3C, 1'b0);

    // Reset after the 3rd data bit of 0x12: no pulse, outputs cleared.
    pat = 8'h12;
    send_bit(1'b0, SB);
    for (int i = 0; i < 3; i++) send_bit(pat[i], SB);
    reset = 1'b0;
    #1;
    chk("mid-frame reset outputs", {dout, rx_done_tick, frame_err}, 10'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ticks(20);
    chk("mid-frame reset pulses", obs_q.size(), 0);
    chk("mid-frame reset dout", dout, 8'h00);
    send_frame(8'hFF, 1'b1, 0, 4, sc);
    check_frame("FF after reset", 8'hFF, 1'b0);

    // Table: break with a held-low line, recovery, back-to-back frames, low stop bits.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].low_after, tbl[i].gap, sc);
      check_frame($sformatf("vec%0d", i), tbl[i].exp_dout, tbl[i].exp_ferr);
    end
    chk("dout holds after table", dout, last_d);
    chk("frame_err holds after table", frame_err, last_f);

    // Random frames. The reference: each frame yields {data, ~stop}.
    // A low stop bit needs at least one idle tick before the next start bit.
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      la  = stp ? 0 : int'($urandom_range(0, 20));
      gp  = stp ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      send_frame(d, stp, la, gp, sc);
      check_frame($sformatf("rand%0d", i), d, ~stp);
    end
    wait_ticks(10);
    chk("final dout held", dout, last_d);
    chk("final frame_err held", frame_err, last_f);
    chk("final no stray pulses", obs_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
